// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: program-memory fetch bus between sequencer and memory.
// Signals: mem_addr, mem_rd (request), mem_ready, mem_rdata (16-bit word).
interface alu_sequencer_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] mem_addr;
  logic            mem_rd;
  logic            mem_ready;
  logic [15:0]     mem_rdata;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches instructions, strobes exec1, owns CARRY/SKIP.
// Ports: clk, rst_n (async low), run, mem (fetch bus master),
//   instruction/exec1 to ALU, carrystatus/skipstatus out,
//   carryout/carryen/skipout/skipen from ALU.
// Optional: define SEQ_INSTR_COUNT_EN for a 32-bit instr_count output.
module alu_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  alu_sequencer_if.master mem,
  output logic [15:0] instruction,
  output logic        exec1,
  output logic        carrystatus,
  output logic        skipstatus,
  input  logic        carryout,
  input  logic        carryen,
  input  logic        skipout,
  input  logic        skipen
`ifdef SEQ_INSTR_COUNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SKIP,
    S_EXEC1
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic            r_carry;
  logic            r_skip;
  logic            w_skip_nx;

  // SKIP value after this edge; EXEC1 routes on it
  assign w_skip_nx = skipen ? skipout : r_skip;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (run) w_next = r_skip ? S_SKIP : S_FETCH;
      end
      S_FETCH: begin
        if (mem.mem_ready) w_next = S_EXEC1;
      end
      S_SKIP: begin
        w_next = run ? S_FETCH : S_IDLE;
      end
      S_EXEC1: begin
        if (!run) w_next = S_IDLE;
        else      w_next = w_skip_nx ? S_SKIP : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
      r_carry <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (mem.mem_ready) begin
            r_ir <= mem.mem_rdata;
            r_pc <= r_pc + 1'b1;
          end
        end
        S_SKIP: begin
          r_pc   <= r_pc + 1'b1;
          r_skip <= 1'b0;
        end
        S_EXEC1: begin
          if (carryen) r_carry <= carryout;
          if (skipen)  r_skip  <= skipout;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_INSTR_COUNT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (r_state == S_EXEC1) r_cnt <= r_cnt + 32'd1;
  end

  assign instr_count = r_cnt;
`endif

  assign mem.mem_rd   = (r_state == S_FETCH);
  assign mem.mem_addr = r_pc;
  assign exec1        = (r_state == S_EXEC1);
  assign instruction  = r_ir;
  assign carrystatus  = r_carry;
  assign skipstatus   = r_skip;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed scenarios plus a randomized run
// checked against an instruction-level reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        mem_ready;
  logic [15:0] junk;
  logic [15:0] instruction;
  logic        exec1;
  logic        carrystatus;
  logic        skipstatus;
  logic        carryout;
  logic        carryen;
  logic        skipout;
  logic        skipen;
`ifdef SEQ_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  logic [15:0] mem [256];
  int tests = 0;
  int fails = 0;

  alu_sequencer_if #(.PC_W(8)) mif ();

  assign mif.mem_ready = mem_ready;
  assign mif.mem_rdata = mem_ready ? mem[mif.mem_addr] : junk;

  alu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .mem(mif.master),
    .instruction(instruction),
    .exec1(exec1),
    .carrystatus(carrystatus),
    .skipstatus(skipstatus),
    .carryout(carryout),
    .carryen(carryen),
    .skipout(skipout),
    .skipen(skipen)
`ifdef SEQ_INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    junk = 16'($urandom);
  endtask

  task automatic flags(input logic ce, co, se, so);
    carryen = ce; carryout = co; skipen = se; skipout = so;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
    flags(0, 0, 0, 0);
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({mif.mem_rd, exec1, mif.mem_addr, carrystatus, skipstatus}
          !== 12'h0) begin
        fails++;
        $display("FAIL reset_idle cyc%0d rd=%b ex=%b addr=%h c=%b s=%b",
                 i, mif.mem_rd, exec1, mif.mem_addr, carrystatus,
                 skipstatus);
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if ({mif.mem_rd, exec1, mif.mem_addr} !== {2'b10, 8'(k)}) begin
        fails++;
        $display("FAIL stream_fetch%0d rd=%b ex=%b addr=%h want addr=%h",
                 k, mif.mem_rd, exec1, mif.mem_addr, 8'(k));
      end
      step();
      tests++;
      if ({mif.mem_rd, exec1, instruction} !==
          {2'b01, 16'hC000 + 16'(k)}) begin
        fails++;
        $display("FAIL stream_exec%0d rd=%b ex=%b ir=%h want ir=%h",
                 k, mif.mem_rd, exec1, instruction, 16'hC000 + 16'(k));
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if ({mif.mem_rd, exec1, mif.mem_addr} !== {2'b10, 8'h05}) begin
        fails++;
        $display("FAIL wait_hold%0d rd=%b ex=%b addr=%h want 1/0/05",
                 i, mif.mem_rd, exec1, mif.mem_addr);
      end
      if (i == 3) mem_ready = 1'b1;
    end
    step();
    tests++;
    if ({exec1, instruction} !== {1'b1, 16'hC005}) begin
      fails++;
      $display("FAIL wait_exec ex=%b ir=%h want 1/C005", exec1, instruction);
    end
    step();
    tests++;
    if ({mif.mem_rd, mif.mem_addr} !== {1'b1, 8'h06}) begin
      fails++;
      $display("FAIL wait_next rd=%b addr=%h want 1/06",
               mif.mem_rd, mif.mem_addr);
    end
  endtask

  task automatic test_flags();
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    step(); step();
    tests++;
    if ({exec1, instruction} !== {1'b1, 16'hC000}) begin
      fails++;
      $display("FAIL flags_exec0 ex=%b ir=%h", exec1, instruction);
    end
    flags(1, 1, 1, 1);
    step();
    tests++;
    if ({mif.mem_rd, exec1, carrystatus, skipstatus} !== 4'b0011) begin
      fails++;
      $display("FAIL flags_skipcyc rd/ex/c/s=%b%b%b%b want 0011",
               mif.mem_rd, exec1, carrystatus, skipstatus);
    end
    flags(0, 0, 0, 0);
    step();
    tests++;
    if ({mif.mem_rd, mif.mem_addr, carrystatus, skipstatus} !==
        {1'b1, 8'h02, 2'b10}) begin
      fails++;
      $display("FAIL flags_after_skip rd=%b addr=%h c=%b s=%b want 1/02/1/0",
               mif.mem_rd, mif.mem_addr, carrystatus, skipstatus);
    end
    step();
    flags(0, 0, 0, 1);
    step();
    tests++;
    if ({mif.mem_addr, carrystatus, skipstatus} !== {8'h03, 2'b10}) begin
      fails++;
      $display("FAIL flags_hold_carry addr=%h c=%b s=%b want 03/1/0",
               mif.mem_addr, carrystatus, skipstatus);
    end
    step();
    flags(1, 0, 1, 1);
    run = 1'b0;
    step();
    tests++;
    if ({mif.mem_rd, exec1, mif.mem_addr, carrystatus, skipstatus} !==
        {2'b00, 8'h04, 2'b01}) begin
      fails++;
      $display("FAIL flags_idle rd=%b ex=%b addr=%h c=%b s=%b want 0/0/04/0/1",
               mif.mem_rd, exec1, mif.mem_addr, carrystatus, skipstatus);
    end
    flags(1, 1, 1, 0);
    step();
    tests++;
    if ({carrystatus, skipstatus} !== 2'b01) begin
      fails++;
      $display("FAIL flags_hold_skip c=%b s=%b want 0/1",
               carrystatus, skipstatus);
    end
    flags(0, 0, 0, 0);
    run = 1'b1;
    step();
    tests++;
    if ({mif.mem_rd, exec1, mif.mem_addr, skipstatus} !==
        {2'b00, 8'h04, 1'b1}) begin
      fails++;
      $display("FAIL flags_idle_skip rd=%b ex=%b addr=%h s=%b want 0/0/04/1",
               mif.mem_rd, exec1, mif.mem_addr, skipstatus);
    end
    step();
    tests++;
    if ({mif.mem_rd, mif.mem_addr, skipstatus} !== {1'b1, 8'h05, 1'b0}) begin
      fails++;
      $display("FAIL flags_resume rd=%b addr=%h s=%b want 1/05/0",
               mif.mem_rd, mif.mem_addr, skipstatus);
    end
  endtask

  task automatic test_abort();
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    step(); step();
    flags(1, 1, 1, 1);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mif.mem_rd, exec1, carrystatus, skipstatus, mif.mem_addr,
         instruction} !== 28'h0) begin
      fails++;
      $display("FAIL abort_now rd=%b ex=%b c=%b s=%b addr=%h ir=%h",
               mif.mem_rd, exec1, carrystatus, skipstatus, mif.mem_addr,
               instruction);
    end
    step();
    rst_n = 1'b1;
    flags(0, 0, 0, 0);
    run = 1'b0;
    step();
    tests++;
    if ({mif.mem_rd, exec1, carrystatus, skipstatus} !== 4'b0000) begin
      fails++;
      $display("FAIL abort_after rd=%b ex=%b c=%b s=%b",
               mif.mem_rd, exec1, carrystatus, skipstatus);
    end
  endtask

  task automatic test_wrap_run_drop();
    bit found = 0;
`ifdef SEQ_INSTR_COUNT_EN
    logic [31:0] c0;
`endif
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (mif.mem_rd === 1'b1 && mif.mem_addr === 8'hFF) found = 1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL wrap_reach addr=%h never reached FF", mif.mem_addr);
    end
`ifdef SEQ_INSTR_COUNT_EN
    c0 = instr_count;
`endif
    mem_ready = 1'b0;
    run = 1'b0;
    step();
    tests++;
    if ({mif.mem_rd, mif.mem_addr} !== {1'b1, 8'hFF}) begin
      fails++;
      $display("FAIL wrap_hold rd=%b addr=%h want 1/FF",
               mif.mem_rd, mif.mem_addr);
    end
    mem_ready = 1'b1;
    step();
    tests++;
    if ({exec1, instruction} !== {1'b1, 16'hC0FF}) begin
      fails++;
      $display("FAIL wrap_exec ex=%b ir=%h want 1/C0FF", exec1, instruction);
    end
    step();
    tests++;
    if ({mif.mem_rd, exec1, mif.mem_addr} !== {2'b00, 8'h00}) begin
      fails++;
      $display("FAIL wrap_idle rd=%b ex=%b addr=%h want 0/0/00",
               mif.mem_rd, exec1, mif.mem_addr);
    end
    step();
    tests++;
    if ({mif.mem_rd, exec1} !== 2'b00) begin
      fails++;
      $display("FAIL wrap_stay rd=%b ex=%b want 0/0", mif.mem_rd, exec1);
    end
`ifdef SEQ_INSTR_COUNT_EN
    tests++;
    if (instr_count !== c0 + 32'd1) begin
      fails++;
      $display("FAIL wrap_count got=%0d want=%0d", instr_count, c0 + 1);
    end
`endif
  endtask

  // Reference: tracks the next fetch address, last fetched word,
  // flags and which kind of cycle the spec says comes next.
  task automatic test_random();
    typedef enum {P_IDLE, P_FETCH, P_SKIP, P_EXEC} phase_t;
    phase_t ph = P_IDLE;
    logic [7:0]  m_pc = 8'h00;
    logic [15:0] m_ir = 16'h0000;
    logic        m_c = 1'b0;
    logic        m_s = 1'b0;
    int          m_cnt = 0;
    logic [27:0] exp_v, obs_v;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      exp_v = {ph == P_FETCH, ph == P_EXEC, m_pc, m_ir, m_c, m_s};
      obs_v = {mif.mem_rd, exec1, mif.mem_addr, instruction,
               carrystatus, skipstatus};
      tests++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL random cyc%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      run       = ($urandom_range(0, 9) != 0);
      mem_ready = 1'($urandom_range(0, 1));
      flags(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom));
      case (ph)
        P_IDLE:  if (run) ph = m_s ? P_SKIP : P_FETCH;
        P_FETCH: if (mem_ready) begin
          m_ir = mem[m_pc];
          m_pc = m_pc + 8'd1;
          ph   = P_EXEC;
        end
        P_SKIP: begin
          m_pc = m_pc + 8'd1;
          m_s  = 1'b0;
          ph   = run ? P_FETCH : P_IDLE;
        end
        P_EXEC: begin
          if (carryen) m_c = carryout;
          if (skipen)  m_s = skipout;
          m_cnt++;
          ph = !run ? P_IDLE : (m_s ? P_SKIP : P_FETCH);
        end
        default: ph = P_IDLE;
      endcase
      step();
    end
`ifdef SEQ_INSTR_COUNT_EN
    tests++;
    if (instr_count !== 32'(m_cnt)) begin
      fails++;
      $display("FAIL random_count got=%0d want=%0d", instr_count, m_cnt);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; junk = 16'h0;
    flags(0, 0, 0, 0);
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000 + 16'(i);
    test_reset();
    test_stream();
    test_wait_states();
    test_flags();
    test_abort();
    test_wrap_run_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Instruction sequencer that drives the ALU's inputs and absorbs its flag outputs.
- Fetches 16-bit instructions from program memory over a ready handshake.
- Holds IR', PC, and the CARRY and SKIP flip-flops.
- Issues the single-cycle exec1 strobe.
- Applies the ALU's carryout/carryen and skipout/skipen, and honours SKIP by discarding the next instruction.

Parameters:
PC_W, 8, program counter and memory address width in bits.
RESET_PC, 0, PC value loaded on reset (PC_W bits).

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  1 = sequencer may start new fetches
mem_addr  output  PC_W  program memory address (= PC during FETCH)
mem_rd  output  1  fetch request, held until mem_ready
mem_ready  input  1  memory has valid mem_rdata this cycle
mem_rdata  input  16  fetched instruction word
instruction  output  16  IR' contents to ALU
exec1  output  1  one-cycle execute strobe to ALU
carrystatus  output  1  CARRY flip-flop Q
skipstatus  output  1  SKIP flip-flop Q
carryout  input  1  ALU CARRY D input
carryen  input  1  ALU CARRY enable
skipout  input  1  ALU SKIP D input
skipen  input  1  ALU SKIP enable

Behaviour:
- Reset (async, rst_n=0), all outputs registered or decoded from registered state:
  - state=IDLE, pc=RESET_PC, ir=16'h0000.
  - carry=0, skip=0.
  - exec1=0, mem_rd=0, mem_addr=RESET_PC.
- Outputs:
  - mem_rd = (state==FETCH).
  - exec1 = (state==EXEC1).
  - mem_addr = pc.
  - instruction = ir.
  - carrystatus = carry, skipstatus = skip.
- State machine, states IDLE, FETCH, SKIP, EXEC1:
  - IDLE: run=1 and skip=0 -> FETCH. run=1 and skip=1 -> SKIP. run=0 -> stay.
  - FETCH: mem_rd=1, mem_addr=pc held stable until handshake.
    - mem_ready=1 -> ir<=mem_rdata, pc<=pc+1, next EXEC1.
    - mem_ready=0 -> stay, no register changes.
  - SKIP: one cycle, no memory access. pc<=pc+1, skip<=0, ir unchanged. Next: run ? FETCH : IDLE.
  - EXEC1: exec1=1 for exactly one cycle.
    - carryen=1 -> carry<=carryout. skipen=1 -> skip<=skipout. Flags otherwise unchanged.
    - Next state uses the value skip will hold after this edge (skipen ? skipout : skip): run=1 and that value=1 -> SKIP; run=1 and that value=0 -> FETCH; run=0 -> IDLE.
- Throughput: 2 cycles per instruction with zero-wait memory (FETCH+EXEC1), plus 1 cycle per extra wait state. A skipped instruction costs 1 cycle and is never read from memory.
- pc wraps modulo 2^PC_W (all-ones + 1 -> 0), no flag or stall.
- run deasserted during FETCH: the handshake completes and the EXEC1 for that instruction still occurs, then the block goes to IDLE. No fetch is ever abandoned.
- Non-ARM instruction words (bits 15:14 != 2'b11) go through EXEC1 like any other. Write gating is the ALU's responsibility.
- carry and skip change only in EXEC1, SKIP, or reset.
- mem_rdata is ignored whenever mem_rd=0.
- Reset asserted mid-FETCH or mid-EXEC1 aborts immediately. No flag update from the aborted cycle.

Optional Feature:
Macro SEQ_INSTR_COUNT_EN.
- Defined: adds output instr_count (32 bits), reset to 0, incremented on every EXEC1 cycle. It does not increment on SKIP cycles. It wraps at 2^32.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset/idle: rst_n=0 then 1 with run=0 for 10 cycles -> mem_rd=0, exec1=0, mem_addr=0, carrystatus=0, skipstatus=0 throughout.
- Zero-wait stream: run=1, mem_ready=1, memory word[i]=16'hC000+i -> exec1 high every 2nd cycle. instruction=16'hC000, C001, C002 on successive exec1. mem_addr 0,1,2.
- Wait states: mem_ready low 3 cycles at addr 5 -> mem_rd held and mem_addr=5 stable for 4 cycles. Single exec1 follows. pc=6 afterwards.
- Carry/skip update: during exec1, carryen=1, carryout=1, skipen=1, skipout=1 -> carrystatus=1 next cycle. Next cycle is SKIP with no mem_rd and pc advances by 1. skipstatus=0 after. Next fetch is at original pc+2.
- Flag hold: exec1 with carryen=0, carryout=0 while carry=1 -> carrystatus remains 1. Same check for skip with skipen=0.
- Wrap and run drop: PC_W=8, pc=8'hFF, run dropped during the FETCH wait -> exec1 still fires once, pc=8'h00, state IDLE, mem_rd=0. With SEQ_INSTR_COUNT_EN, instr_count increments by exactly 1.
